// File: rtl/prach_pkg.sv
// Shared types, latencies and the round/saturate helper for the PRACH conversion chain.
package prach_pkg;

    localparam int NcoLatency = 4;
    localparam int MixLatency = 4;
    localparam int RndShift   = 14;

    typedef logic signed [15:0] iq_t;

    typedef struct packed {
        logic       sync;
        logic       dv;
        logic [7:0] chn;
    } tdm_sb_t;

    typedef struct packed {
        iq_t     i;
        iq_t     q;
        tdm_sb_t sb;
    } iq_word_t;

    typedef struct packed {
        iq_t  val;
        logic sat;
    } rnd_t;

    // Drops 14 of the 29 fractional bits, rounding half toward +inf, then clamps to 16 bits.
    function automatic rnd_t round_sat(input logic signed [32:0] s);
        logic signed [32:0] r;
        rnd_t               res;
        r = (s + 33'sd8192) >>> RndShift;
        if (r > 33'sd32767) begin
            res.val = 16'sh7fff;
            res.sat = 1'b1;
        end else if (r < -33'sd32768) begin
            res.val = 16'sh8000;
            res.sat = 1'b1;
        end else begin
            res.val = r[15:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/prach_cmult_rnd.sv
// Three-stage complex multiply x*e^(-j*phi) with round/saturate: products, sums, then round+clamp.
module prach_cmult_rnd
    import prach_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  iq_t  x_i_i,
    input  iq_t  x_q_i,
    input  iq_t  w_cos_i,
    input  iq_t  w_sin_i,
    output iq_t  y_i_o,
    output iq_t  y_q_o,
    output logic sat_o
);

    logic signed [31:0] p_ic_q, p_qs_q, p_qc_q, p_is_q;
    logic signed [32:0] sum_i_q, sum_q_q;
    logic signed [32:0] sum_i_d, sum_q_d;
    rnd_t               rnd_i, rnd_q;

    assign sum_i_d = 33'(p_ic_q) + 33'(p_qs_q);
    assign sum_q_d = 33'(p_qc_q) - 33'(p_is_q);
    assign rnd_i   = round_sat(sum_i_q);
    assign rnd_q   = round_sat(sum_q_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_ic_q  <= '0;
            p_qs_q  <= '0;
            p_qc_q  <= '0;
            p_is_q  <= '0;
            sum_i_q <= '0;
            sum_q_q <= '0;
            y_i_o   <= '0;
            y_q_o   <= '0;
            sat_o   <= 1'b0;
        end else begin
            p_ic_q  <= 32'(x_i_i) * 32'(w_cos_i);
            p_qs_q  <= 32'(x_q_i) * 32'(w_sin_i);
            p_qc_q  <= 32'(x_q_i) * 32'(w_cos_i);
            p_is_q  <= 32'(x_i_i) * 32'(w_sin_i);
            sum_i_q <= sum_i_d;
            sum_q_q <= sum_q_d;
            y_i_o   <= rnd_i.val;
            y_q_o   <= rnd_q.val;
            sat_o   <= rnd_i.sat | rnd_q.sat;
        end
    end

endmodule

// File: rtl/prach_delay.sv
// Fixed-depth register delay line, cleared by reset so nothing stale leaks out after a flush.
module prach_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset (not left as uninitialised storage) so a mid-stream reset cannot replay old dv/sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value on the same edge.
            stage_q[0] <= din_i;
            for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/prach_conv_mixer.sv
// Complex down-mixer behind prach_conv_nco: aligns data to the NCO, mixes, rounds/saturates,
// checks NCO/data sideband alignment and counts saturated outputs per frame.
module prach_conv_mixer
    import prach_pkg::*;
#(
    parameter int NCO_LATENCY = NcoLatency,
    parameter int MIX_LATENCY = MixLatency
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din_i,
    input  logic [15:0] din_q,
    input  logic [7:0]  din_chn,
    input  logic        din_dv,
    input  logic        sync_in,
    input  logic [15:0] nco_cos,
    input  logic [15:0] nco_sin,
    input  logic [7:0]  nco_chn,
    input  logic        nco_dv,
    input  logic        nco_sync,
    output logic [15:0] dout_i,
    output logic [15:0] dout_q,
    output logic [7:0]  dout_chn,
    output logic        dout_dv,
    output logic        sync_out,
    output logic [15:0] sat_cnt,
    output logic        align_err
);

    if (MIX_LATENCY != MixLatency) begin : g_bad_mix_latency
        $error("prach_conv_mixer: MIX_LATENCY is fixed at %0d", MixLatency);
    end

    iq_word_t    din_word, d_word;
    tdm_sb_t     dout_sb;
    iq_t         s1_i_q, s1_q_q, s1_cos_q, s1_sin_q;
    iq_t         mix_i, mix_q;
    logic        mix_sat;
    logic        sb_mismatch, sat_hit;
    logic        align_err_q, align_err_d;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    assign din_word = '{i: din_i, q: din_q, sb: '{sync: sync_in, dv: din_dv, chn: din_chn}};

    prach_delay #(.WIDTH($bits(iq_word_t)), .DEPTH(NCO_LATENCY)) u_data_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (din_word),
        .dout_o (d_word)
    );

    // The sideband skips the S1 input registers inside the mixer but takes the same total MIX_LATENCY.
    prach_delay #(.WIDTH($bits(tdm_sb_t)), .DEPTH(MIX_LATENCY)) u_sb_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (d_word.sb),
        .dout_o (dout_sb)
    );

    prach_cmult_rnd u_cmult (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_i_i   (s1_i_q),
        .x_q_i   (s1_q_q),
        .w_cos_i (s1_cos_q),
        .w_sin_i (s1_sin_q),
        .y_i_o   (mix_i),
        .y_q_o   (mix_q),
        .sat_o   (mix_sat)
    );

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can infer a latch.
        align_err_d = align_err_q;
        sat_cnt_d   = sat_cnt_q;
        sat_hit     = dout_sb.dv & mix_sat;
        sb_mismatch = (d_word.sb.sync != nco_sync) || (d_word.sb.dv != nco_dv)
                   || (d_word.sb.dv && (d_word.sb.chn != nco_chn));

        if (sb_mismatch)         align_err_d = 1'b1;
        else if (d_word.sb.sync) align_err_d = 1'b0;

        // The frame count includes the sample currently on dout, so sat_cnt is shown from sat_cnt_d.
        if (dout_sb.sync)                          sat_cnt_d = {15'd0, sat_hit};
        else if (sat_hit && sat_cnt_q != 16'hffff) sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_i_q      <= '0;
            s1_q_q      <= '0;
            s1_cos_q    <= '0;
            s1_sin_q    <= '0;
            align_err_q <= 1'b0;
            sat_cnt_q   <= '0;
        end else begin
            s1_i_q      <= d_word.i;
            s1_q_q      <= d_word.q;
            s1_cos_q    <= nco_cos;
            s1_sin_q    <= nco_sin;
            align_err_q <= align_err_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign dout_i    = dout_sb.dv ? mix_i : '0;
    assign dout_q    = dout_sb.dv ? mix_q : '0;
    assign dout_chn  = dout_sb.chn;
    assign dout_dv   = dout_sb.dv;
    assign sync_out  = dout_sb.sync;
    assign sat_cnt   = sat_cnt_d;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_prach_conv_mixer.sv
// Randomised and directed bench for prach_conv_mixer; the bench also plays the NCO by replaying
// each sample's cos/sin and sideband four cycles after the sample itself.
module tb_prach_conv_mixer;

    typedef struct {
        shortint    i;
        shortint    q;
        shortint    cos;
        shortint    sin;
        logic [7:0] chn;
        bit         dv;
        bit         sync;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din_i, din_q, nco_cos, nco_sin;
    logic [7:0]  din_chn, nco_chn;
    logic        din_dv, sync_in, nco_dv, nco_sync;
    logic [15:0] dout_i, dout_q, sat_cnt;
    logic [7:0]  dout_chn;
    logic        dout_dv, sync_out, align_err;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    bit   skew    = 0;
    bit   exp_align = 0;
    int   exp_cnt   = 0;
    bit   watch_dv  = 0;
    int   first_dv  = -1;
    rec_t ring [16];

    always #5 clk = ~clk;

    prach_conv_mixer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_i     (din_i),
        .din_q     (din_q),
        .din_chn   (din_chn),
        .din_dv    (din_dv),
        .sync_in   (sync_in),
        .nco_cos   (nco_cos),
        .nco_sin   (nco_sin),
        .nco_chn   (nco_chn),
        .nco_dv    (nco_dv),
        .nco_sync  (nco_sync),
        .dout_i    (dout_i),
        .dout_q    (dout_q),
        .dout_chn  (dout_chn),
        .dout_dv   (dout_dv),
        .sync_out  (sync_out),
        .sat_cnt   (sat_cnt),
        .align_err (align_err)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic rec_t mk(int i, int q, int c, int s, int chn, bit dv, bit sync);
        rec_t r;
        r.i = shortint'(i);  r.q = shortint'(q);
        r.cos = shortint'(c); r.sin = shortint'(s);
        r.chn = 8'(chn); r.dv = dv; r.sync = sync;
        return r;
    endfunction

    function automatic rec_t rnd_rec(int chn);
        rec_t r;
        r.i = shortint'($urandom);   r.q = shortint'($urandom);
        r.cos = shortint'($urandom); r.sin = shortint'($urandom);
        r.chn = (chn < 0) ? 8'($urandom_range(0, 255)) : 8'(chn);
        r.dv = ($urandom_range(0, 3) != 0);
        r.sync = ($urandom_range(0, 15) == 0);
        return r;
    endfunction

    // Exact complex product x*(cos - j*sin) scaled by 2^-14, rounded half up, clamped to 16 bits.
    function automatic void ref_mix(input rec_t r, output int ei, output int eq, output bit sat);
        longint si, sq;
        si = (longint'(r.i) * r.cos + longint'(r.q) * r.sin + 8192) >>> 14;
        sq = (longint'(r.q) * r.cos - longint'(r.i) * r.sin + 8192) >>> 14;
        sat = (si > 32767) || (si < -32768) || (sq > 32767) || (sq < -32768);
        ei = (si > 32767) ? 32767 : (si < -32768) ? -32768 : int'(si);
        eq = (sq > 32767) ? 32767 : (sq < -32768) ? -32768 : int'(sq);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 16; k++) ring[k] = mk(0, 0, 0, 0, 0, 0, 0);
        cyc = 0; exp_align = 0; exp_cnt = 0;
        din_i = '0; din_q = '0; din_chn = '0; din_dv = 0; sync_in = 0;
        nco_cos = '0; nco_sin = '0; nco_chn = '0; nco_dv = 0; nco_sync = 0;
    endtask

    task automatic tick(input rec_t r);
        rec_t n4, n5, o8;
        int   ei, eq;
        bit   es, hit, mm;
        @(posedge clk); #1;
        ring[cyc & 15] = r;
        n4 = ring[(cyc - 4) & 15];
        n5 = ring[(cyc - 5) & 15];
        din_i = r.i; din_q = r.q; din_chn = r.chn; din_dv = r.dv; sync_in = r.sync;
        nco_cos = n4.cos; nco_sin = n4.sin; nco_chn = n4.chn;
        nco_dv = skew ? n5.dv : n4.dv;
        nco_sync = n4.sync;
        @(negedge clk);
        o8 = ring[(cyc - 8) & 15];
        ref_mix(o8, ei, eq, es);
        hit = o8.dv && es;
        if (o8.sync)                   exp_cnt = hit ? 1 : 0;
        else if (hit && exp_cnt < 65535) exp_cnt++;
        check("dout_i", $signed(dout_i), o8.dv ? ei : 0);
        check("dout_q", $signed(dout_q), o8.dv ? eq : 0);
        check("dout_chn", dout_chn, o8.chn);
        check("dout_dv", dout_dv, o8.dv);
        check("sync_out", sync_out, o8.sync);
        check("sat_cnt", sat_cnt, exp_cnt);
        check("align_err", align_err, exp_align);
        if (watch_dv && dout_dv && first_dv < 0) first_dv = cyc;
        mm = (n4.sync != nco_sync) || (n4.dv != nco_dv) || (n4.dv && n4.chn != nco_chn);
        if (mm)           exp_align = 1;
        else if (n4.sync) exp_align = 0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i"}, dout_i, 0);
        check({tag, "_q"}, dout_q, 0);
        check({tag, "_chn"}, dout_chn, 0);
        check({tag, "_dv"}, dout_dv, 0);
        check({tag, "_sync"}, sync_out, 0);
        check({tag, "_satcnt"}, sat_cnt, 0);
        check({tag, "_alerr"}, align_err, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Phase zero, rounding and saturation corner cases.
        tick(mk(1000, -2000, 16384, 0, 5, 1, 1));
        idle(10);
        check("phase0_satcnt", sat_cnt, 0);
        tick(mk(1, 0, 8192, 0, 1, 1, 0));
        tick(mk(-1, 0, 8192, 0, 2, 1, 0));
        tick(mk(32767, 32767, 11585, 11585, 3, 1, 0));
        tick(mk(-32768, 0, -16384, 0, 4, 1, 0));
        tick(mk(-32768, 0, 16384, 0, 5, 1, 0));
        idle(10);
        check("corner_satcnt", sat_cnt, 2);

        for (int k = 0; k < 400; k++) tick(rnd_rec(-1));
        idle(10);

        // NCO dv lags by one extra cycle: the toggling dv pattern must trip align_err.
        skew = 1;
        for (int k = 0; k < 20; k++) tick(mk(100, 100, 16384, 0, k % 8, k % 2, 0));
        idle(6);
        check("skew_sticky", align_err, 1);
        skew = 0;
        idle(6);
        check("skew_held", align_err, 1);
        tick(mk(0, 0, 0, 0, 0, 0, 1));
        idle(6);
        check("skew_clear", align_err, 0);

        // Frame counting: three saturations then a clean sync, then a saturated sync.
        tick(mk(10, 10, 16384, 0, 0, 1, 1));
        for (int k = 0; k < 3; k++) tick(mk(-32768, 0, -16384, 0, k, 1, 0));
        tick(mk(10, 10, 16384, 0, 0, 1, 1));
        idle(10);
        check("frame_clean", sat_cnt, 0);
        tick(mk(-32768, 0, -16384, 0, 0, 1, 1));
        idle(10);
        check("frame_satsync", sat_cnt, 1);

        for (int k = 0; k < 70000; k++) tick(mk(-32768, 0, -16384, 0, k % 8, 1, 0));
        idle(10);
        check("sat_hold", sat_cnt, 65535);

        // Reset mid-stream with eight channels in flight.
        for (int k = 0; k < 20; k++) tick(rnd_rec(k % 8));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        watch_dv = 1;
        for (int k = 0; k < 24; k++) begin
            rec_t r;
            r = rnd_rec(k % 8);
            r.dv = 1;
            tick(r);
        end
        idle(10);
        check("first_dv_lat", first_dv, 8);
        check("post_rst_align", align_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
